// File: rtl/image_row_streamer.sv
// Streams a bottom-up bitmap image, stored flipped so row 0 is the top, toward a convolution engine.
// A few rows are primed back-to-back; after that, each interrupt rising edge releases one further row.
module image_row_streamer #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int PRIME_ROWS = 4,
    parameter int HDR_SKIP   = 1078
) (
    input  logic       axi_clk,
    input  logic       axi_rst_n,
    input  logic       s_load_valid,
    input  logic [7:0] s_load_data,
    output logic       s_load_ready,
    input  logic       i_start,
    input  logic       i_intr,
    output logic       o_data_valid,
    output logic [7:0] o_data,
    output logic       o_busy,
    output logic       o_done
);

    localparam int NPIX      = IMG_W * IMG_H;
    localparam int ADDR_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int COL_W     = $clog2(IMG_W + 1);
    localparam int ROW_W     = $clog2(IMG_H + 1);
    localparam int LOAD_W    = $clog2(NPIX + HDR_SKIP + 1);
    localparam int PRIME_LIM = (PRIME_ROWS < 1) ? 1 : ((PRIME_ROWS < IMG_H) ? PRIME_ROWS : IMG_H);

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0]  ROWS_END  = ROW_W'(IMG_H);
    localparam logic [ROW_W-1:0]  PRIME_END = ROW_W'(PRIME_LIM);
    localparam logic [LOAD_W-1:0] HDR_END   = LOAD_W'(HDR_SKIP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_PRIME,
        S_GAP,
        S_WAIT_INTR,
        S_ROW,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [LOAD_W-1:0] r_loadCnt;
    logic [ROW_W-1:0]  r_ldRow;
    logic [COL_W-1:0]  r_ldCol;
    logic [ROW_W-1:0]  r_rdRow;
    logic [COL_W-1:0]  r_rdCol;
    logic              r_pending;
    logic              r_intrPrev;
    logic              r_dataValid;
    logic [7:0]        r_data;
    logic              r_done;
    logic [7:0]        r_mem [0:NPIX-1];

    logic              w_intrRise;
    logic              w_accept;
    logic              w_inHeader;
    logic              w_pixWrite;
    logic              w_rowEnd;
    logic [ROW_W-1:0]  w_wrRowIdx;
    logic [ADDR_W-1:0] w_wrAddr;
    logic [ADDR_W-1:0] w_rdAddr;

    assign w_intrRise = i_intr & ~r_intrPrev;
    assign w_accept   = s_load_valid && (r_state == S_IDLE);
    assign w_inHeader = (r_loadCnt < HDR_END);
    assign w_pixWrite = axi_rst_n && w_accept && !w_inHeader;
    assign w_rowEnd   = (r_rdCol == LAST_COL);

    // Loader rows arrive bottom-first, so the write row counts down from the last image row.
    assign w_wrRowIdx = LAST_ROW - r_ldRow;
    assign w_wrAddr   = ADDR_W'(32'(w_wrRowIdx) * IMG_W + 32'(r_ldCol));
    assign w_rdAddr   = ADDR_W'(32'(r_rdRow) * IMG_W + 32'(r_rdCol));

    assign s_load_ready = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE) && (r_state != S_READY);
    assign o_data_valid = r_dataValid;
    assign o_data       = r_data;
    assign o_done       = r_done;

    always_ff @(posedge axi_clk) begin
        if (w_pixWrite) begin
            r_mem[w_wrAddr] <= s_load_data;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            r_state     <= S_IDLE;
            r_loadCnt   <= '0;
            r_ldRow     <= '0;
            r_ldCol     <= '0;
            r_rdRow     <= '0;
            r_rdCol     <= '0;
            r_pending   <= 1'b0;
            r_intrPrev  <= 1'b0;
            r_dataValid <= 1'b0;
            r_data      <= 8'h00;
            r_done      <= 1'b0;
        end else begin
            r_intrPrev <= i_intr;
            r_done     <= 1'b0;
            // Only one early request is remembered; extra edges while it is pending are dropped.
            if (w_intrRise && (r_state == S_PRIME || r_state == S_ROW || r_state == S_GAP)) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_loadCnt <= r_loadCnt + LOAD_W'(1);
                        if (!w_inHeader) begin
                            if (r_ldCol == LAST_COL) begin
                                r_ldCol <= '0;
                                r_ldRow <= r_ldRow + ROW_W'(1);
                                if (r_ldRow == LAST_ROW) begin
                                    r_state <= S_READY;
                                end
                            end else begin
                                r_ldCol <= r_ldCol + COL_W'(1);
                            end
                        end
                    end
                end
                S_READY: begin
                    if (i_start) begin
                        r_state <= S_PRIME;
                    end
                end
                S_PRIME, S_ROW: begin
                    r_dataValid <= 1'b1;
                    r_data      <= r_mem[w_rdAddr];
                    if (w_rowEnd) begin
                        r_rdCol <= '0;
                        r_rdRow <= r_rdRow + ROW_W'(1);
                        if (r_state == S_ROW || (r_rdRow + ROW_W'(1)) == PRIME_END) begin
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_rdCol <= r_rdCol + COL_W'(1);
                    end
                end
                S_GAP: begin
                    r_dataValid <= 1'b0;
                    if (r_rdRow == ROWS_END) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_WAIT_INTR;
                    end
                end
                S_WAIT_INTR: begin
                    if (r_pending || w_intrRise) begin
                        r_pending <= 1'b0;
                        r_state   <= S_ROW;
                    end
                end
                S_DONE: begin
                    r_pending <= 1'b0;
                    r_loadCnt <= '0;
                    r_ldRow   <= '0;
                    r_ldCol   <= '0;
                    r_rdRow   <= '0;
                    r_rdCol   <= '0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_row_streamer.sv
// Directed bench for image_row_streamer: load, prime, interrupt-driven rows, pending edges, reset.
module tb_image_row_streamer;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int HDR   = 1078;
    localparam int NPIX  = IMG_W * IMG_H;

    logic       axi_clk = 1'b0;
    logic       axi_rst_n;
    logic       s_load_valid;
    logic [7:0] s_load_data;
    logic       s_load_ready;
    logic       i_start;
    logic       i_intr;
    logic       o_data_valid;
    logic [7:0] o_data;
    logic       o_busy;
    logic       o_done;

    int checks = 0;
    int passed = 0;

    image_row_streamer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PRIME_ROWS(4), .HDR_SKIP(HDR)
    ) dut (
        .axi_clk(axi_clk), .axi_rst_n(axi_rst_n),
        .s_load_valid(s_load_valid), .s_load_data(s_load_data), .s_load_ready(s_load_ready),
        .i_start(i_start), .i_intr(i_intr),
        .o_data_valid(o_data_valid), .o_data(o_data), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 axi_clk = ~axi_clk;

    function automatic logic [7:0] pixVal(input int k, input int pat);
        if (pat == 0) return 8'(k % 256);
        return 8'((k * 7 + 3) % 256);
    endfunction

    // Expected pixel for display row r (row 0 = top), i.e. the vertically flipped file order.
    function automatic logic [7:0] expPix(input int r, input int c, input int pat);
        return pixVal((IMG_H - 1 - r) * IMG_W + c, pat);
    endfunction

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic load_image(input int pat, input bit gappy, input bit holdStart, output int busySeen);
        busySeen = 0;
        i_start  = holdStart;
        for (int i = 0; i < HDR + NPIX; i++) begin
            if (gappy) begin
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 0; g++) begin
                    s_load_valid = 1'b0;
                    tick();
                    if (o_busy) busySeen++;
                end
            end
            s_load_valid = 1'b1;
            s_load_data  = (i < HDR) ? 8'(i ^ 8'h5A) : pixVal(i - HDR, pat);
            if (i == HDR + NPIX - 1) i_start = 1'b0;
            tick();
            if (o_busy) busySeen++;
        end
        s_load_data = 8'hFF;
        tick();
        tick();
        s_load_valid = 1'b0;
    endtask

    task automatic capture_burst(input int pat, input int startRow, input int maxWait,
                                 output int nPix, output int badPix, output int waited,
                                 output logic [7:0] firstPix);
        nPix = 0; badPix = 0; waited = 0; firstPix = 8'h00;
        tick();
        while (!o_data_valid && waited < maxWait) begin
            waited++;
            tick();
        end
        while (o_data_valid && nPix < 2 * NPIX) begin
            if (nPix == 0) firstPix = o_data;
            if (o_data !== expPix(startRow + nPix / IMG_W, nPix % IMG_W, pat)) badPix++;
            nPix++;
            tick();
        end
    endtask

    task automatic run_rows(input int pat, input int first, input int last,
                            output int ok, output bit doneSeen);
        int n, b, w;
        logic [7:0] fp;
        ok = 0; doneSeen = 1'b0;
        for (int r = first; r <= last; r++) begin
            i_intr = 1'b1;
            capture_burst(pat, r, 4, n, b, w, fp);
            if (n == IMG_W && b == 0 && w == 1 && o_done === (r == IMG_H - 1)) ok++;
            if (r == last) doneSeen = o_done;
            i_intr = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        axi_rst_n = 1'b0; s_load_valid = 1'b0; s_load_data = 8'h00; i_start = 1'b0; i_intr = 1'b0;
        tick(); tick();
        axi_rst_n = 1'b1;
        checks++; if (s_load_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", s_load_ready); else passed++;
        checks++; if (o_data_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", o_data_valid); else passed++;
        checks++; if (o_data !== 8'h00) $display("[TB] FAIL reset_data: got %h want 00", o_data); else passed++;
        checks++; if (o_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", o_busy); else passed++;
        checks++; if (o_done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", o_done); else passed++;
    endtask

    task automatic test_stream();
        int n, b, w, ok, vcnt, busySeen;
        logic [7:0] fp;
        bit d;
        load_image(0, 1'b0, 1'b0, busySeen);
        checks++; if (s_load_ready !== 1'b0) $display("[TB] FAIL loaded_ready: got %b want 0", s_load_ready); else passed++;
        i_start = 1'b1; tick(); i_start = 1'b0;
        checks++; if (o_data_valid !== 1'b0 || o_busy !== 1'b1) $display("[TB] FAIL start_state: got valid=%b busy=%b want 0/1", o_data_valid, o_busy); else passed++;
        capture_burst(0, 0, 4, n, b, w, fp);
        checks++; if (n != 112) $display("[TB] FAIL prime_len: got %0d want 112", n); else passed++;
        checks++; if (b != 0) $display("[TB] FAIL prime_pixels: got %0d bad want 0", b); else passed++;
        checks++; if (w != 0) $display("[TB] FAIL prime_latency: got %0d want 0", w); else passed++;
        checks++; if (fp !== 8'hF4) $display("[TB] FAIL prime_first: got %h want f4", fp); else passed++;
        vcnt = 0;
        repeat (5) begin
            if (o_data_valid || o_done) vcnt++;
            tick();
        end
        checks++; if (vcnt != 0) $display("[TB] FAIL wait_silent: got %0d valid want 0", vcnt); else passed++;
        run_rows(0, 4, 27, ok, d);
        checks++; if (ok != 24) $display("[TB] FAIL intr_rows: got %0d good rows want 24", ok); else passed++;
        checks++; if (d !== 1'b1) $display("[TB] FAIL done_pulse: got %b want 1", d); else passed++;
        checks++; if (o_done !== 1'b0 || o_busy !== 1'b0 || s_load_ready !== 1'b1)
            $display("[TB] FAIL back_to_idle: got done=%b busy=%b ready=%b want 0/0/1", o_done, o_busy, s_load_ready);
        else passed++;
    endtask

    task automatic test_double_intr();
        int n, b, w, ok, busySeen;
        logic [7:0] fp;
        bit d;
        load_image(1, 1'b1, 1'b1, busySeen);
        checks++; if (busySeen != 0) $display("[TB] FAIL start_during_load: got %0d busy cycles want 0", busySeen); else passed++;
        checks++; if (s_load_ready !== 1'b0 || o_busy !== 1'b0) $display("[TB] FAIL gappy_ready: got ready=%b busy=%b want 0/0", s_load_ready, o_busy); else passed++;
        i_start = 1'b1; tick(); i_start = 1'b0;
        capture_burst(1, 0, 4, n, b, w, fp);
        checks++; if (n != 112 || b != 0) $display("[TB] FAIL gappy_prime: got len=%0d bad=%0d want 112/0", n, b); else passed++;
        i_intr = 1'b1; tick(); i_intr = 1'b0;
        w = 0; n = 0; b = 0;
        tick();
        while (!o_data_valid && w < 4) begin w++; tick(); end
        while (o_data_valid && n < 2 * IMG_W) begin
            if (o_data !== expPix(4, n, 1)) b++;
            n++;
            i_intr = (n == 5 || n == 6 || n == 10 || n == 11);
            tick();
        end
        i_intr = 1'b0;
        checks++; if (n != IMG_W || b != 0) $display("[TB] FAIL row4_burst: got len=%0d bad=%0d want 28/0", n, b); else passed++;
        capture_burst(1, 5, 6, n, b, w, fp);
        checks++; if (n != IMG_W || b != 0 || w != 1) $display("[TB] FAIL pending_row: got len=%0d bad=%0d wait=%0d want 28/0/1", n, b, w); else passed++;
        capture_burst(1, 6, 10, n, b, w, fp);
        checks++; if (n != 0) $display("[TB] FAIL second_pulse_lost: got %0d pixels want 0", n); else passed++;
        run_rows(1, 6, 27, ok, d);
        checks++; if (ok != 22 || d !== 1'b1) $display("[TB] FAIL rest_rows: got ok=%0d done=%b want 22/1", ok, d); else passed++;
    endtask

    task automatic test_held_and_reset();
        int n, b, w, ok, vcnt, busySeen;
        logic [7:0] fp;
        bit d;
        load_image(0, 1'b0, 1'b0, busySeen);
        i_intr = 1'b1; tick(); tick();
        i_start = 1'b1; tick(); i_start = 1'b0;
        capture_burst(0, 0, 4, n, b, w, fp);
        checks++; if (n != 112 || b != 0) $display("[TB] FAIL held_prime: got len=%0d bad=%0d want 112/0", n, b); else passed++;
        vcnt = 0;
        repeat (10) begin
            if (o_data_valid) vcnt++;
            tick();
        end
        checks++; if (vcnt != 0) $display("[TB] FAIL intr_held_high: got %0d valid want 0", vcnt); else passed++;
        i_intr = 1'b0; tick();
        run_rows(0, 4, 9, ok, d);
        checks++; if (ok != 6 || d !== 1'b0) $display("[TB] FAIL rows_4_9: got ok=%0d done=%b want 6/0", ok, d); else passed++;
        i_intr = 1'b1; tick(); tick();
        for (int c = 0; c < 13; c++) tick();
        checks++; if (o_data_valid !== 1'b1 || o_data !== expPix(10, 13, 0))
            $display("[TB] FAIL row10_col13: got valid=%b data=%h want 1/%h", o_data_valid, o_data, expPix(10, 13, 0));
        else passed++;
        axi_rst_n = 1'b0; i_intr = 1'b0; tick();
        checks++; if (o_data_valid !== 1'b0 || o_busy !== 1'b0 || s_load_ready !== 1'b1 || o_done !== 1'b0 || o_data !== 8'h00)
            $display("[TB] FAIL midrow_reset: got valid=%b busy=%b ready=%b done=%b data=%h want 0/0/1/0/00",
                     o_data_valid, o_busy, s_load_ready, o_done, o_data);
        else passed++;
        axi_rst_n = 1'b1; tick();
        load_image(1, 1'b0, 1'b0, busySeen);
        i_start = 1'b1; tick(); i_start = 1'b0;
        capture_burst(1, 0, 4, n, b, w, fp);
        checks++; if (n != 112 || b != 0 || fp !== expPix(0, 0, 1))
            $display("[TB] FAIL restart_prime: got len=%0d bad=%0d first=%h want 112/0/%h", n, b, fp, expPix(0, 0, 1));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_double_intr();
        test_held_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
